mbist_data_cmp_log: RTL

Multi-lane MBIST read-data comparator with a failing-address log, the parametrised successor of the single-lane comparator in the MBIST core. Splits each read word into independently checked lanes and keeps a repair log of up to BIST_LOG_DEPTH failing addresses with their lane masks. The log is drained through a valid/ready port by the repair/status logic. Sits between the MBIST FSM/pattern generator and the repair-address register bank.

---
 rtl/mbist_data_cmp_log_if.sv | 41 ++++
 rtl/mbist_data_cmp_log.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mbist_data_cmp_log_if.sv
// Bundle between the MBIST FSM / pattern generator, the comparator and the repair-log consumer.
interface mbist_data_cmp_log_if #(
   parameter int unsigned BIST_ADDR_WD   = 9,
   parameter int unsigned BIST_DATA_WD   = 32,
   parameter int unsigned BIST_LANE_CNT  = 4,
   parameter int unsigned BIST_LOG_DEPTH = 4
);
   localparam int unsigned CW = $clog2(BIST_LOG_DEPTH + 1);

   // Compare request side
   logic                     clear;
   logic                     compare;
   logic                     addr_inc_phase;
   logic                     read_invert;
   logic [BIST_DATA_WD-1:0]  comp_data;
   logic [BIST_DATA_WD-1:0]  rxd_data;
   logic [BIST_ADDR_WD-1:0]  addr;

   // Status side
   logic                     error;
   logic                     correct;
   logic                     error_correct;
   logic [CW-1:0]            error_cnt;
   logic [BIST_LANE_CNT-1:0] lane_fail;

   // Repair-log drain port
   logic                     log_valid;
   logic                     log_ready;
   logic [BIST_ADDR_WD-1:0]  log_addr;
   logic [BIST_LANE_CNT-1:0] log_lane;

   modport master (
      output clear, compare, addr_inc_phase, read_invert, comp_data, rxd_data, addr, log_ready,
      input  error, correct, error_correct, error_cnt, lane_fail, log_valid, log_addr, log_lane
   );

   modport slave (
      input  clear, compare, addr_inc_phase, read_invert, comp_data, rxd_data, addr, log_ready,
      output error, correct, error_correct, error_cnt, lane_fail, log_valid, log_addr, log_lane
   );
endinterface

// File: rtl/mbist_data_cmp_log.sv
// Multi-lane MBIST read-data comparator with a failing-address repair log.
// Optional feature macro: MBIST_CMP_DEDUP_EN -- drop fails at addresses already logged since clear.
// Log storage is written at index error_cnt; since pops never decrement the count, the
// storage doubles as the history of every address logged since clear.
module mbist_data_cmp_log #(
   parameter int unsigned BIST_ADDR_WD   = 9,
   parameter int unsigned BIST_DATA_WD   = 32,
   parameter int unsigned BIST_LANE_CNT  = 4,
   parameter int unsigned BIST_LOG_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mbist_data_cmp_log_if.slave   bus
);
   localparam int unsigned LW = BIST_DATA_WD / BIST_LANE_CNT;
   localparam int unsigned CW = $clog2(BIST_LOG_DEPTH + 1);

   // Stage-1 registers
   logic                     s1_vld_q,  s1_vld_d;
   logic [BIST_LANE_CNT-1:0] s1_lane_q, s1_lane_d;
   logic [BIST_ADDR_WD-1:0]  s1_addr_q, s1_addr_d;

   // Stage-2 / status registers
   logic                     mask_q,      mask_d;
   logic                     error_q,     error_d;
   logic                     correct_q,   correct_d;
   logic [CW-1:0]            cnt_q,       cnt_d;
   logic [BIST_LANE_CNT-1:0] lane_fail_q, lane_fail_d;
   logic [CW-1:0]            rd_q,        rd_d;
   logic                     log_valid_q, log_valid_d;
   logic [BIST_ADDR_WD-1:0]  log_addr_q,  log_addr_d;
   logic [BIST_LANE_CNT-1:0] log_lane_q,  log_lane_d;

   // Log storage
   logic [BIST_ADDR_WD-1:0]  mem_addr_q [BIST_LOG_DEPTH];
   logic [BIST_LANE_CNT-1:0] mem_lane_q [BIST_LOG_DEPTH];

   logic [BIST_DATA_WD-1:0]  exp_data;
   logic [BIST_DATA_WD-1:0]  diff;
   logic                     s1_fail;
   logic                     fail;
   logic                     room;
   logic                     dup;
   logic                     log_event;
   logic                     push;
   logic                     pop;
   logic                     error_correct_c;

   // Per-lane mismatch against the (optionally inverted) expected pattern
   always_comb begin
      exp_data  = bus.read_invert ? ~bus.comp_data : bus.comp_data;
      diff      = exp_data ^ bus.rxd_data;
      s1_lane_d = '0;
      for (int i = 0; i < int'(BIST_LANE_CNT); i++) begin
         s1_lane_d[i] = |diff[i*LW +: LW];
      end
   end

   // Next-state logic for stage 1, stage 2, log pointers and registered head
   always_comb begin
      s1_vld_d    = s1_vld_q;
      s1_addr_d   = s1_addr_q;
      mask_d      = mask_q;
      error_d     = error_q;
      correct_d   = correct_q;
      cnt_d       = cnt_q;
      lane_fail_d = lane_fail_q;
      rd_d        = rd_q;
      log_valid_d = 1'b0;
      log_addr_d  = '0;
      log_lane_d  = '0;
      dup         = 1'b0;

      s1_fail   = s1_vld_q && (|s1_lane_q);
      fail      = s1_fail && !mask_q;
      room      = cnt_q < CW'(BIST_LOG_DEPTH);
`ifdef MBIST_CMP_DEDUP_EN
      for (int i = 0; i < int'(BIST_LOG_DEPTH); i++) begin
         if ((CW'(i) < cnt_q) && (mem_addr_q[i] == s1_addr_q)) dup = 1'b1;
      end
`endif
      log_event = fail && !dup;
      push      = log_event && room;
      pop       = log_valid_q && bus.log_ready;
      error_correct_c = fail && room;

      s1_vld_d  = bus.compare && !mask_q;
      s1_addr_d = bus.addr;
      // A new fail re-arms the mask even if the FSM is stepping the address
      mask_d    = log_event || (mask_q && !bus.addr_inc_phase);

      if (push) begin
         cnt_d       = cnt_q + CW'(1);
         correct_d   = 1'b1;
         lane_fail_d = lane_fail_q | s1_lane_q;
      end
      if (fail && dup) lane_fail_d = lane_fail_q | s1_lane_q;
      if (log_event && !room) error_d = 1'b1;
      if (pop) rd_d = rd_q + CW'(1);

      log_valid_d = (rd_d != cnt_d);
      if (log_valid_d) begin
         if (push && (rd_d == cnt_q)) begin
            log_addr_d = s1_addr_q;
            log_lane_d = s1_lane_q;
         end else begin
            for (int i = 0; i < int'(BIST_LOG_DEPTH); i++) begin
               if (CW'(i) == rd_d) begin
                  log_addr_d = mem_addr_q[i];
                  log_lane_d = mem_lane_q[i];
               end
            end
         end
      end

      if (bus.clear) begin
         s1_vld_d    = 1'b0;
         s1_addr_d   = '0;
         mask_d      = 1'b0;
         error_d     = 1'b0;
         correct_d   = 1'b0;
         cnt_d       = '0;
         lane_fail_d = '0;
         rd_d        = '0;
         log_valid_d = 1'b0;
         log_addr_d  = '0;
         log_lane_d  = '0;
         push        = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q    <= 1'b0;
         s1_lane_q   <= '0;
         s1_addr_q   <= '0;
         mask_q      <= 1'b0;
         error_q     <= 1'b0;
         correct_q   <= 1'b0;
         cnt_q       <= '0;
         lane_fail_q <= '0;
         rd_q        <= '0;
         log_valid_q <= 1'b0;
         log_addr_q  <= '0;
         log_lane_q  <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_lane_q   <= bus.clear ? '0 : s1_lane_d;
         s1_addr_q   <= s1_addr_d;
         mask_q      <= mask_d;
         error_q     <= error_d;
         correct_q   <= correct_d;
         cnt_q       <= cnt_d;
         lane_fail_q <= lane_fail_d;
         rd_q        <= rd_d;
         log_valid_q <= log_valid_d;
         log_addr_q  <= log_addr_d;
         log_lane_q  <= log_lane_d;
      end
   end

   // Log storage write at the current fill index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(BIST_LOG_DEPTH); i++) begin
            mem_addr_q[i] <= '0;
            mem_lane_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(BIST_LOG_DEPTH); i++) begin
            if (push && (CW'(i) == cnt_q)) begin
               mem_addr_q[i] <= s1_addr_q;
               mem_lane_q[i] <= s1_lane_q;
            end
         end
      end
   end

   assign bus.error         = error_q;
   assign bus.correct       = correct_q;
   assign bus.error_correct = error_correct_c;
   assign bus.error_cnt     = cnt_q;
   assign bus.lane_fail     = lane_fail_q;
   assign bus.log_valid     = log_valid_q;
   assign bus.log_addr      = log_addr_q;
   assign bus.log_lane      = log_lane_q;
endmodule
